// File: rtl/washing_machine_controller_param.sv
// rtl/washing_machine_controller_param.sv - parametrised washing machine sequencer
// Internal timers, programmable rinse passes, fill/drain watchdogs and door fault handling.
module washing_machine_controller_param #(
    parameter int CNT_W         = 16,
    parameter int WASH_CYCLES   = 1000,
    parameter int RINSE_CYCLES  = 500,
    parameter int SPIN_CYCLES   = 800,
    parameter int FILL_TIMEOUT  = 4000,
    parameter int DRAIN_TIMEOUT = 4000,
    parameter int RC_W          = 2,
    parameter int MAX_RINSES    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            door_close,
    input  logic            filled,
    input  logic            detergent_added,
    input  logic            drained,
    input  logic            pause,
    input  logic            err_clr,
    input  logic [RC_W-1:0] num_rinses,
    output logic            door_lock,
    output logic            motor_on,
    output logic            fill_valve_on,
    output logic            drain_valve_on,
    output logic            done,
    output logic            error,
    output logic [3:0]      state,
    output logic [RC_W-1:0] rinse_left
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FILL     = 4'd1,
        S_WAIT_DET = 4'd2,
        S_WASH     = 4'd3,
        S_DRAIN    = 4'd4,
        S_RINSE    = 4'd5,
        S_SPIN     = 4'd6,
        S_DONE     = 4'd7,
        S_ERROR    = 4'd8
    } state_e;

    typedef enum logic {
        WASH_PHASE  = 1'b0,
        RINSE_PHASE = 1'b1
    } phase_e;

    // Timers count down from N-1 to 0, so each load is the duration minus one.
    localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMR_ONE    = CNT_W'(1);
    localparam logic [RC_W-1:0]  RC_ONE     = RC_W'(1);
    localparam logic [RC_W-1:0]  RC_MAX     = RC_W'(MAX_RINSES);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [RC_W-1:0]   rinse_q, rinse_d;
    logic [RC_W-1:0]   rinse_load;
    logic              timer_zero;

    assign rinse_load = (int'(num_rinses) > MAX_RINSES) ? RC_MAX : num_rinses;
    assign timer_zero = (timer_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            phase_q <= WASH_PHASE;
            timer_q <= '0;
            rinse_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            rinse_q <= rinse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        rinse_d = rinse_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && door_close) begin
                    state_d = S_FILL;
                    rinse_d = rinse_load;
                    phase_d = WASH_PHASE;
                    timer_d = FILL_LOAD;
                end
            end
            S_FILL: begin
                if (filled) begin
                    if (phase_q == WASH_PHASE) begin
                        state_d = S_WAIT_DET;
                        timer_d = '0;
                    end else begin
                        state_d = S_RINSE;
                        timer_d = RINSE_LOAD;
                    end
                end else if (timer_zero) begin
                    state_d = S_ERROR;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_WAIT_DET: begin
                if (detergent_added) begin
                    state_d = S_WASH;
                    timer_d = WASH_LOAD;
                end
            end
            S_WASH, S_RINSE: begin
                if (!pause) begin
                    if (timer_zero) begin
                        state_d = S_DRAIN;
                        timer_d = DRAIN_LOAD;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
            end
            S_SPIN: begin
                if (!pause) begin
                    if (timer_zero) begin
                        state_d = S_DONE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    if (rinse_q != '0) begin
                        state_d = S_FILL;
                        rinse_d = rinse_q - RC_ONE;
                        phase_d = RINSE_PHASE;
                        timer_d = FILL_LOAD;
                    end else begin
                        state_d = S_SPIN;
                        timer_d = SPIN_LOAD;
                    end
                end else if (timer_zero) begin
                    state_d = S_ERROR;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (err_clr && drained) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        // An open door while the drum is active overrides every other transition.
        if (state_q inside {S_FILL, S_WAIT_DET, S_WASH, S_DRAIN, S_RINSE, S_SPIN} && !door_close) begin
            state_d = S_ERROR;
            phase_d = phase_q;
            rinse_d = rinse_q;
            timer_d = '0;
        end
    end

    always_comb begin
        door_lock      = 1'b0;
        motor_on       = 1'b0;
        fill_valve_on  = 1'b0;
        drain_valve_on = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        unique case (state_q)
            S_FILL: begin
                door_lock     = 1'b1;
                fill_valve_on = 1'b1;
            end
            S_WAIT_DET: door_lock = 1'b1;
            S_WASH, S_RINSE: begin
                door_lock = 1'b1;
                motor_on  = !pause;
            end
            S_DRAIN: begin
                door_lock      = 1'b1;
                drain_valve_on = 1'b1;
            end
            S_SPIN: begin
                door_lock      = 1'b1;
                motor_on       = !pause;
                drain_valve_on = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERROR: begin
                error          = 1'b1;
                drain_valve_on = 1'b1;
                door_lock      = !drained;
            end
            default: ;
        endcase
    end

    assign state      = state_q;
    assign rinse_left = rinse_q;

endmodule

// File: tb/tb_washing_machine_controller_param.sv
// tb/tb_washing_machine_controller_param.sv - randomized scenario bench with schedule-based reference
module tb_washing_machine_controller_param;

    localparam int WASH_C   = 8;
    localparam int RINSE_C  = 4;
    localparam int SPIN_C   = 6;
    localparam int FILL_TO  = 10;
    localparam int DRAIN_TO = 10;
    localparam int MAX_R    = 3;

    localparam int ST_IDLE = 0, ST_FILL = 1, ST_WAIT = 2, ST_WASH = 3, ST_DRAIN = 4;
    localparam int ST_RINSE = 5, ST_SPIN = 6, ST_DONE = 7, ST_ERROR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, door_close, filled, detergent_added, drained, pause, err_clr;
    logic [1:0] num_rinses;
    logic       door_lock, motor_on, fill_valve_on, drain_valve_on, done, error;
    logic [3:0] state;
    logic [1:0] rinse_left;
    logic       door_lock2, motor_on2, fill_valve_on2, drain_valve_on2, done2, error2;
    logic [3:0] state2;
    logic [1:0] rinse_left2;

    washing_machine_controller_param #(
        .CNT_W(16), .WASH_CYCLES(WASH_C), .RINSE_CYCLES(RINSE_C), .SPIN_CYCLES(SPIN_C),
        .FILL_TIMEOUT(FILL_TO), .DRAIN_TIMEOUT(DRAIN_TO), .RC_W(2), .MAX_RINSES(MAX_R)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .door_close(door_close), .filled(filled),
        .detergent_added(detergent_added), .drained(drained), .pause(pause), .err_clr(err_clr),
        .num_rinses(num_rinses), .door_lock(door_lock), .motor_on(motor_on),
        .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on), .done(done),
        .error(error), .state(state), .rinse_left(rinse_left)
    );

    washing_machine_controller_param #(
        .CNT_W(16), .WASH_CYCLES(WASH_C), .RINSE_CYCLES(RINSE_C), .SPIN_CYCLES(SPIN_C),
        .FILL_TIMEOUT(FILL_TO), .DRAIN_TIMEOUT(DRAIN_TO), .RC_W(2), .MAX_RINSES(2)
    ) dut_clamp (
        .clk(clk), .rst(rst), .start(start), .door_close(door_close), .filled(filled),
        .detergent_added(detergent_added), .drained(drained), .pause(pause), .err_clr(err_clr),
        .num_rinses(num_rinses), .door_lock(door_lock2), .motor_on(motor_on2),
        .fill_valve_on(fill_valve_on2), .drain_valve_on(drain_valve_on2), .done(done2),
        .error(error2), .state(state2), .rinse_left(rinse_left2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       st;
        bit       start, door, filled, det, drained, pause, errclr;
        bit [1:0] nr;
        int       rl;
    } ent_t;

    ent_t     sched[$];
    int       rl_g;
    bit [1:0] nr_g;
    int       errors = 0;
    int       checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input int v);
        return (v < 0) ? bit'($urandom_range(0, 1)) : bit'(v);
    endfunction

    // -1 marks an input that is irrelevant in that state and gets random noise.
    task automatic add(input int st, input int s, input int door, input int fl,
                       input int det, input int dr, input int pz, input int ec);
        ent_t e;
        e.st      = st;
        e.start   = pick(s);
        e.door    = pick(door);
        e.filled  = pick(fl);
        e.det     = pick(det);
        e.drained = pick(dr);
        e.pause   = pick(pz);
        e.errclr  = pick(ec);
        e.nr      = (st == ST_IDLE) ? nr_g : 2'($urandom_range(0, 3));
        e.rl      = rl_g;
        sched.push_back(e);
    endtask

    function automatic logic [5:0] exp_outs(input ent_t e);
        case (e.st)
            ST_FILL:           return 6'b101000;
            ST_WAIT:           return 6'b100000;
            ST_WASH, ST_RINSE: return {1'b1, ~e.pause, 4'b0000};
            ST_DRAIN:          return 6'b100100;
            ST_SPIN:           return {1'b1, ~e.pause, 4'b0100};
            ST_DONE:           return 6'b000010;
            ST_ERROR:          return {~e.drained, 5'b00101};
            default:           return 6'b000000;
        endcase
    endfunction

    task automatic fill_seg(input int f);
        repeat (f) add(ST_FILL, -1, 1, 0, -1, -1, -1, -1);
        add(ST_FILL, -1, 1, 1, -1, -1, -1, -1);
    endtask

    task automatic wait_seg(input int d);
        repeat (d) add(ST_WAIT, -1, 1, -1, 0, -1, -1, -1);
        add(ST_WAIT, -1, 1, -1, 1, -1, -1, -1);
    endtask

    // A motor phase is n unpaused cycles with a block of p paused cycles starting at k.
    task automatic motor_seg(input int st, input int n, input int p, input int k);
        for (int i = 0; i < n + p; i++)
            add(st, -1, 1, -1, -1, -1, (i >= k && i < k + p) ? 1 : 0, -1);
    endtask

    task automatic drain_seg(input int r);
        repeat (r) add(ST_DRAIN, -1, 1, -1, -1, 0, -1, -1);
        add(ST_DRAIN, -1, 1, -1, -1, 1, -1, -1);
    endtask

    task automatic error_tail();
        int e1, e2;
        e1 = $urandom_range(1, 3);
        e2 = $urandom_range(0, 2);
        repeat (e1) add(ST_ERROR, -1, -1, -1, -1, 0, -1, -1);
        repeat (e2) add(ST_ERROR, -1, -1, -1, -1, 1, -1, 0);
        add(ST_ERROR, -1, -1, -1, -1, 1, -1, 1);
        add(ST_IDLE, 0, -1, -1, -1, -1, -1, -1);
    endtask

    task automatic build_normal(input bit [1:0] nr, input bit directed, input int wash_p);
        int p, h;
        sched.delete();
        rl_g = 0;
        nr_g = nr;
        if (!directed && $urandom_range(0, 1) == 1) add(ST_IDLE, 1, 0, -1, -1, -1, -1, -1);
        add(ST_IDLE, 1, 1, -1, -1, -1, -1, -1);
        rl_g = (int'(nr) > MAX_R) ? MAX_R : int'(nr);
        fill_seg(directed ? 3 : $urandom_range(0, 6));
        wait_seg(directed ? 2 : $urandom_range(0, 4));
        p = directed ? wash_p : $urandom_range(0, 4);
        motor_seg(ST_WASH, WASH_C, p, directed ? 2 : $urandom_range(0, WASH_C - 1));
        drain_seg(directed ? 2 : $urandom_range(0, 6));
        while (rl_g > 0) begin
            rl_g--;
            fill_seg(directed ? 3 : $urandom_range(0, 6));
            p = directed ? 0 : $urandom_range(0, 3);
            motor_seg(ST_RINSE, RINSE_C, p, $urandom_range(0, RINSE_C - 1));
            drain_seg(directed ? 2 : $urandom_range(0, 6));
        end
        p = directed ? 0 : $urandom_range(0, 3);
        motor_seg(ST_SPIN, SPIN_C, p, $urandom_range(0, SPIN_C - 1));
        h = directed ? 1 : $urandom_range(0, 3);
        repeat (h) add(ST_DONE, 1, -1, -1, -1, -1, -1, -1);
        add(ST_DONE, 0, -1, -1, -1, -1, -1, -1);
        add(ST_IDLE, 0, -1, -1, -1, -1, -1, -1);
    endtask

    task automatic cut_to(input int n);
        while (sched.size() > n) void'(sched.pop_back());
    endtask

    // mode 1: fill watchdog, 2: drain watchdog, 3: door fault, 4: async reset mid-drain
    task automatic apply_mode(input int mode, input bit directed);
        int idx[$];
        int j, rl;
        case (mode)
            1, 2: begin
                foreach (sched[i]) if (sched[i].st == ((mode == 1) ? ST_FILL : ST_DRAIN)) idx.push_back(i);
                j  = idx[0];
                rl = sched[j].rl;
                cut_to(j);
                rl_g = rl;
                if (mode == 1) repeat (FILL_TO) add(ST_FILL, -1, 1, 0, -1, -1, -1, -1);
                else           repeat (DRAIN_TO) add(ST_DRAIN, -1, 1, -1, -1, 0, -1, -1);
                error_tail();
            end
            3: begin
                foreach (sched[i])
                    if (directed ? (sched[i].st == ST_SPIN) : (sched[i].st >= ST_FILL && sched[i].st <= ST_SPIN))
                        idx.push_back(i);
                j = idx[$urandom_range(0, idx.size() - 1)];
                cut_to(j + 1);
                sched[j].door = 1'b0;
                rl_g = sched[j].rl;
                error_tail();
            end
            4: begin
                foreach (sched[i]) if (sched[i].st == ST_DRAIN) idx.push_back(i);
                j = idx[$urandom_range(0, idx.size() - 1)];
                cut_to(j + 1);
            end
            default: ;
        endcase
    endtask

    task automatic drive(input ent_t e);
        start           = e.start;
        door_close      = e.door;
        filled          = e.filled;
        detergent_added = e.det;
        drained         = e.drained;
        pause           = e.pause;
        err_clr         = e.errclr;
        num_rinses      = e.nr;
    endtask

    task automatic run_sched(input bit arst, input bit chk_ovr, output int motor_cnt);
        bit seen_fill;
        logic [5:0] outs;
        seen_fill = 1'b0;
        motor_cnt = 0;
        rst = 1'b0;
        start = 0; door_close = 0; filled = 0; detergent_added = 0;
        drained = 0; pause = 0; err_clr = 0; num_rinses = 0;
        @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_outs", {door_lock, motor_on, fill_valve_on, drain_valve_on, done, error}, 0);
        chk("reset_rinse_left", rinse_left, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < sched.size(); i++) begin
            drive(sched[i]);
            @(negedge clk);
            outs = {door_lock, motor_on, fill_valve_on, drain_valve_on, done, error};
            chk($sformatf("state[%0d]", i), state, sched[i].st);
            chk($sformatf("outs[%0d]", i), outs, exp_outs(sched[i]));
            chk($sformatf("rinse_left[%0d]", i), rinse_left, sched[i].rl);
            if (motor_on) motor_cnt++;
            if (chk_ovr && !seen_fill && sched[i].st == ST_FILL) begin
                chk("clamp_rinse_left", rinse_left2, 2);
                seen_fill = 1'b1;
            end
            if (arst && i == sched.size() - 1) begin
                #2 rst = 1'b0;
                #1;
                chk("arst_state", state, 0);
                chk("arst_outs", {door_lock, motor_on, fill_valve_on, drain_valve_on, done, error}, 0);
                chk("arst_rinse_left", rinse_left, 0);
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int mc, mode;
        bit [1:0] nr;

        build_normal(2'd0, 1'b1, 0);
        run_sched(1'b0, 1'b0, mc);
        chk("motor_cnt_basic", mc, WASH_C + SPIN_C);

        build_normal(2'd2, 1'b1, 0);
        run_sched(1'b0, 1'b0, mc);
        chk("motor_cnt_rinse2", mc, WASH_C + 2 * RINSE_C + SPIN_C);

        build_normal(2'd3, 1'b1, 0);
        run_sched(1'b0, 1'b1, mc);

        build_normal(2'd0, 1'b1, 5);
        run_sched(1'b0, 1'b0, mc);
        chk("motor_cnt_pause", mc, WASH_C + SPIN_C);

        for (int m = 1; m <= 4; m++) begin
            build_normal(2'd1, 1'b1, 0);
            apply_mode(m, 1'b1);
            run_sched(m == 4, 1'b0, mc);
        end

        for (int it = 0; it < 40; it++) begin
            nr   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 4);
            build_normal(nr, 1'b0, 0);
            apply_mode(mode, 1'b0);
            run_sched(mode == 4, nr == 2'd3, mc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/washing_machine_controller_param.md
Name: washing_machine_controller_param

Overview:
- Parametrised successor to the fixed-sequence washing machine FSM.
- Internal down-counter timers replace the external wash and spin timeout inputs.
- Adds a programmable number of rinse passes (fill, rinse, drain), fill and drain watchdogs with a safe ERROR state, pause/resume of motor phases, and a door-open fault.
- Sits between front-panel/sensor inputs and the actuator drivers.

Parameters:
- CNT_W, 16: timer width; every *_CYCLES/*_TIMEOUT value must be in 1..2^CNT_W.
- WASH_CYCLES, 1000: unpaused clock cycles spent in WASH.
- RINSE_CYCLES, 500: unpaused clock cycles per RINSE pass.
- SPIN_CYCLES, 800: unpaused clock cycles in SPIN.
- FILL_TIMEOUT, 4000: maximum cycles in FILL before ERROR.
- DRAIN_TIMEOUT, 4000: maximum cycles in DRAIN before ERROR.
- RC_W, 2: width of num_rinses.
- MAX_RINSES, 3: clamp applied to num_rinses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level; begin cycle from IDLE; release from DONE.
- door_close  in  1  door sensor, 1 = closed.
- filled  in  1  water level reached.
- detergent_added  in  1  detergent confirmed.
- drained  in  1  drum empty.
- pause  in  1  freezes WASH/RINSE/SPIN timers, motor off.
- err_clr  in  1  operator acknowledge of ERROR.
- num_rinses  in  RC_W  rinse passes; sampled on the IDLE->FILL transition.
- door_lock  out  1  door solenoid.
- motor_on  out  1  drum motor.
- fill_valve_on  out  1  inlet valve.
- drain_valve_on  out  1  drain pump/valve.
- done  out  1  cycle complete.
- error  out  1  fault state active.
- state  out  4  current state encoding (debug).
- rinse_left  out  RC_W  remaining rinse passes.

Behaviour:
- Reset (rst=0, async): state=IDLE, timer=0, rinse_left=0, phase=WASH_PHASE. All outputs 0 while reset is held and after release.
- Moore outputs are decoded from the registered state, so they change in the same cycle as the state register.
- State encoding and outputs:
  - IDLE=0: all outputs 0.
  - FILL=1: lock, fill.
  - WAIT_DET=2: lock.
  - WASH=3: lock, motor (motor=0 while pause=1).
  - DRAIN=4: lock, drain.
  - RINSE=5: lock, motor (motor=0 while pause=1).
  - SPIN=6: lock, motor, drain (motor=0 while pause=1).
  - DONE=7: done=1, lock=0.
  - ERROR=8: error=1, drain=1, lock=~drained.
- IDLE -> FILL when start=1 and door_close=1.
  - Load rinse_left=min(num_rinses, MAX_RINSES).
  - Set phase=WASH_PHASE.
  - Load timer=FILL_TIMEOUT-1.
  - start=1 with door open: stay in IDLE.
- FILL:
  - filled=1 -> WAIT_DET if phase=WASH_PHASE, else -> RINSE.
  - Otherwise, timer==0 -> ERROR.
  - Otherwise decrement the timer.
  - filled wins over timeout in the same cycle.
- WAIT_DET -> WASH when detergent_added=1, loading timer=WASH_CYCLES-1. No timeout in WAIT_DET.
- WASH/RINSE/SPIN:
  - pause=1: timer holds, state holds.
  - pause=0 and timer==0: exit.
  - pause=0 and timer!=0: decrement.
  - Each phase therefore lasts exactly N unpaused cycles.
  - WASH and RINSE exit to DRAIN, loading timer=DRAIN_TIMEOUT-1.
  - SPIN exits to DONE.
- DRAIN: on drained=1:
  - rinse_left>0 -> FILL; rinse_left decrements; phase=RINSE_PHASE; timer=FILL_TIMEOUT-1.
  - rinse_left==0 -> SPIN; timer=SPIN_CYCLES-1.
  - Without drained, timer==0 -> ERROR. drained wins over timeout in the same cycle.
- DONE -> IDLE when start=0. If start is held at 1, the machine stays in DONE (no auto-restart).
- Door fault: door_close=0 in any state FILL..SPIN -> ERROR next cycle. This has priority over every other transition.
- ERROR -> IDLE only when err_clr=1 and drained=1. door_close is ignored in ERROR.
- Reset mid-operation: immediate return to IDLE. All valves and motor off asynchronously.
- The timer never underflows; it is reloaded on every state entry.

Test Plan (bench params WASH=8, RINSE=4, SPIN=6, FILL_TO=10, DRAIN_TO=10, RC_W=2, MAX_RINSES=3):
- Normal, num_rinses=0: start+door, filled after 3 cycles, detergent after 2, drained after 2. Expect state trace 0,1,2,3(x8),4,6(x6),7; motor_on high exactly 14 cycles; done=1; then start=0 -> IDLE with all outputs 0.
- num_rinses=2: expect two FILL->RINSE(x4)->DRAIN loops; WAIT_DET visited once; rinse_left steps 2,1,0; then SPIN.
- num_rinses=3 with MAX_RINSES=2 (override): expect rinse_left loaded as 2.
- Pause: pause=1 for 5 cycles mid-WASH. Expect WASH to last 13 cycles total, motor_on=0 during pause, door_lock=1 throughout.
- Fill watchdog: filled never asserted -> ERROR on the 11th FILL cycle; fill off, drain on, error=1, lock=1. Then drained=1: lock=0; then err_clr=1 -> IDLE.
- Door opened during SPIN -> ERROR next cycle, motor_on=0.
- rst=0 asserted asynchronously mid-DRAIN: all outputs 0 before the next clock edge; state=0.
